console_writer: RTL and testbench

- Character-stream front end for the text buffer: accepts one byte per valid/ready transfer and performs the memory writes needed to render it on screen.
- Maintains the cursor, interprets control codes, and hardware-scrolls the screen through the buffer's addr/we/oe/di/do CPU port.
- Sits directly upstream of the text buffer. It drives the buffer port in place of the CPU bus; top-level muxing selects between the two.

---
 rtl/console_pkg.sv | 32 +++
 rtl/console_writer.sv | 202 ++++++++++++++++++++
 tb/tb_console_writer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/console_pkg.sv
// Shared definitions for the console character-stream writer.
package console_pkg;

  // Control codes interpreted by the writer; every other byte is printable.
  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_CR = 8'h0D;

  // Default screen geometry and the resulting offset of the attribute plane.
  localparam int unsigned DEF_WIDTH      = 20;
  localparam int unsigned DEF_HEIGHT     = 16;
  localparam int unsigned ATTR_PLANE_OFS = DEF_WIDTH * DEF_HEIGHT;

  typedef enum logic [2:0] {
    IDLE,
    WR_CHAR,
    WR_ATTR,
    SCROLL_RD,
    SCROLL_WR,
    CLRROW,
    CLEAR
  } state_e;

  // Buffer address: sum formed at 16 bits, then truncated to the 12-bit port.
  function automatic logic [11:0] buf_addr(input logic [15:0] base, input int unsigned ofs);
    logic [15:0] a;
    a = base + 16'(ofs);
    return a[11:0];
  endfunction

endpackage

// File: rtl/console_writer.sv
// Character-stream front end for the text buffer: renders bytes, tracks the
// cursor, interprets control codes and scrolls/clears through the CPU port.
module console_writer
  import console_pkg::*;
#(
  parameter int unsigned WIDTH    = 20,
  parameter int unsigned HEIGHT   = 16,
  parameter logic [15:0] BASEADDR = 16'h400,
  parameter logic [7:0]  BLANK    = 8'h20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_char,
  input  logic [7:0]                in_attr,
  output logic [11:0]               addr,
  output logic                      we,
  output logic                      oe,
  output logic [7:0]                wdata,
  input  logic [7:0]                rdata,
  output logic [$clog2(WIDTH)-1:0]  cursor_col,
  output logic [$clog2(HEIGHT)-1:0] cursor_row,
  output logic                      busy
);

  localparam int unsigned CW       = $clog2(WIDTH);
  localparam int unsigned RW       = $clog2(HEIGHT);
  localparam int unsigned CELLS    = WIDTH * HEIGHT;
  localparam int unsigned COPIES   = WIDTH * (HEIGHT - 1);
  localparam int unsigned LAST_ROW = (HEIGHT - 1) * WIDTH;
  localparam int unsigned IW       = $clog2(2 * CELLS);

  localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
  localparam logic [IW-1:0] COPY_END   = IW'(2 * COPIES - 1);
  localparam logic [IW-1:0] CLRROW_END = IW'(2 * WIDTH - 1);
  localparam logic [IW-1:0] CLEAR_END  = IW'(2 * CELLS - 1);

  state_e        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nx;
  logic [7:0]    attr_lat;
  logic [7:0]    wdata_reg;
  int unsigned   cell_pos;

  // Copy index walks the char plane first, then the attr plane; src is one row below dst.
  function automatic logic [11:0] copy_addr(input logic [IW-1:0] i, input logic src);
    int unsigned n;
    int unsigned plane;
    n     = 32'(i);
    plane = 0;
    if (n >= COPIES) begin
      n     = n - COPIES;
      plane = CELLS;
    end
    return buf_addr(BASEADDR, plane + n + (src ? WIDTH : 32'd0));
  endfunction

  // Last-row clear: first WIDTH steps hit the char plane, the rest the attr plane.
  function automatic logic [11:0] clrrow_addr(input logic [IW-1:0] i);
    int unsigned n;
    n = 32'(i);
    if (n >= WIDTH) return buf_addr(BASEADDR, CELLS + LAST_ROW + n - WIDTH);
    return buf_addr(BASEADDR, LAST_ROW + n);
  endfunction

  // Current cell position and the shared counter's next value.
  always_comb begin
    cell_pos = 32'(cursor_row) * WIDTH + 32'(cursor_col);
    idx_nx   = idx + IW'(1);
  end

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  // Buffer read data arrives one clock after the read strobe, i.e. during the
  // write cycle, so the copy path forwards it straight to the write port.
  assign wdata    = (state == SCROLL_WR) ? rdata : wdata_reg;

  // Main FSM: cursor, control codes, scroll and clear sequencing, registered buffer strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= BASEADDR[11:0];
      we         <= 1'b0;
      oe         <= 1'b0;
      wdata_reg  <= 8'h00;
      cursor_col <= '0;
      cursor_row <= '0;
      attr_lat   <= 8'h0F;
      idx        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            attr_lat <= in_attr;
            case (in_char)
              CHR_CR: cursor_col <= '0;
              CHR_LF: begin
                cursor_col <= '0;
                if (cursor_row == ROW_LAST) begin
                  state <= SCROLL_RD;
                  oe    <= 1'b1;
                  idx   <= '0;
                  addr  <= copy_addr('0, 1'b1);
                end else begin
                  cursor_row <= cursor_row + RW'(1);
                end
              end
              CHR_BS: if (cursor_col != '0) cursor_col <= cursor_col - CW'(1);
              CHR_FF: begin
                state     <= CLEAR;
                we        <= 1'b1;
                idx       <= '0;
                addr      <= buf_addr(BASEADDR, 0);
                wdata_reg <= BLANK;
              end
              default: begin
                state     <= WR_CHAR;
                we        <= 1'b1;
                addr      <= buf_addr(BASEADDR, cell_pos);
                wdata_reg <= in_char;
              end
            endcase
          end
        end
        WR_CHAR: begin
          state     <= WR_ATTR;
          addr      <= buf_addr(BASEADDR, CELLS + cell_pos);
          wdata_reg <= attr_lat;
        end
        WR_ATTR: begin
          we    <= 1'b0;
          state <= IDLE;
          if (cursor_col == COL_LAST) begin
            cursor_col <= '0;
            if (cursor_row == ROW_LAST) begin
              state <= SCROLL_RD;
              oe    <= 1'b1;
              idx   <= '0;
              addr  <= copy_addr('0, 1'b1);
            end else begin
              cursor_row <= cursor_row + RW'(1);
            end
          end else begin
            cursor_col <= cursor_col + CW'(1);
          end
        end
        SCROLL_RD: begin
          state <= SCROLL_WR;
          oe    <= 1'b0;
          we    <= 1'b1;
          addr  <= copy_addr(idx, 1'b0);
        end
        SCROLL_WR: begin
          if (idx == COPY_END) begin
            state     <= CLRROW;
            idx       <= '0;
            addr      <= clrrow_addr('0);
            wdata_reg <= BLANK;
          end else begin
            state <= SCROLL_RD;
            we    <= 1'b0;
            oe    <= 1'b1;
            idx   <= idx_nx;
            addr  <= copy_addr(idx_nx, 1'b1);
          end
        end
        CLRROW: begin
          if (idx == CLRROW_END) begin
            state <= IDLE;
            we    <= 1'b0;
            idx   <= '0;
          end else begin
            idx       <= idx_nx;
            addr      <= clrrow_addr(idx_nx);
            wdata_reg <= (32'(idx_nx) < WIDTH) ? BLANK : attr_lat;
          end
        end
        CLEAR: begin
          if (idx == CLEAR_END) begin
            state      <= IDLE;
            we         <= 1'b0;
            idx        <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
          end else begin
            idx       <= idx_nx;
            addr      <= buf_addr(BASEADDR, 32'(idx_nx));
            wdata_reg <= (32'(idx_nx) < CELLS) ? BLANK : attr_lat;
          end
        end
        default: begin
          state <= IDLE;
          we    <= 1'b0;
          oe    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_console_writer.sv
// Bench for console_writer: buffer memory model plus a screen-level reference model.
module tb_console_writer;
  import console_pkg::*;

  localparam int W     = 20;
  localparam int H     = 16;
  localparam int CELLS = W * H;
  localparam int BASE  = 'h400;
  localparam int ABASE = BASE + CELLS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic [7:0]  in_attr = 8'h00;
  logic        in_ready;
  logic [11:0] addr;
  logic        we;
  logic        oe;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [4:0]  cursor_col;
  logic [3:0]  cursor_row;
  logic        busy;

  console_writer #(
    .WIDTH(W), .HEIGHT(H), .BASEADDR(16'h400), .BLANK(8'h20)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_attr(in_attr), .addr(addr), .we(we), .oe(oe),
    .wdata(wdata), .rdata(rdata), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Text buffer model: synchronous write, one-clock read latency.
  logic [7:0] mem      [0:4095];
  logic [7:0] init_mem [0:4095];
  logic       load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_mem[i];
      rdata <= 8'h00;
    end else begin
      if (we) mem[addr] <= wdata;
      if (oe) rdata <= mem[addr];
    end
  end

  // Bus monitor, sampled mid-cycle.
  logic [19:0] wr_log[$];
  logic [11:0] rd_log[$];
  int n_conflict = 0;
  int n_idle_strobe = 0;

  always @(negedge clk) begin
    if (we) wr_log.push_back({addr, wdata});
    if (oe) rd_log.push_back(addr);
    if (we && oe) n_conflict++;
    if (in_ready && (we || oe)) n_idle_strobe++;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // Reference screen model.
  logic [7:0] ref_char [CELLS];
  logic [7:0] ref_attr [CELLS];
  int mcol = 0;
  int mrow = 0;
  int last_wb = 0;
  int last_rb = 0;

  task automatic model_scroll(input logic [7:0] a);
    for (int i = 0; i < W * (H - 1); i++) begin
      ref_char[i] = ref_char[i + W];
      ref_attr[i] = ref_attr[i + W];
    end
    for (int i = W * (H - 1); i < CELLS; i++) begin
      ref_char[i] = 8'h20;
      ref_attr[i] = a;
    end
  endtask

  task automatic model_byte(input logic [7:0] c, input logic [7:0] a, output int exp_busy);
    exp_busy = 0;
    case (c)
      8'h0D: mcol = 0;
      8'h08: if (mcol > 0) mcol--;
      8'h0A: begin
        mcol = 0;
        if (mrow == H - 1) begin model_scroll(a); exp_busy = 1240; end
        else mrow++;
      end
      8'h0C: begin
        for (int i = 0; i < CELLS; i++) begin ref_char[i] = 8'h20; ref_attr[i] = a; end
        mcol = 0; mrow = 0; exp_busy = 640;
      end
      default: begin
        ref_char[mrow * W + mcol] = c;
        ref_attr[mrow * W + mcol] = a;
        exp_busy = 2;
        mcol++;
        if (mcol == W) begin
          mcol = 0;
          if (mrow == H - 1) begin model_scroll(a); exp_busy += 1240; end
          else mrow++;
        end
      end
    endcase
  endtask

  task automatic resync_model();
    for (int i = 0; i < CELLS; i++) begin
      ref_char[i] = mem[BASE + i];
      ref_attr[i] = mem[ABASE + i];
    end
  endtask

  task automatic check_screen(input string tag);
    int bad = 0;
    for (int i = 0; i < CELLS; i++) begin
      if (mem[BASE + i] !== ref_char[i]) bad++;
      if (mem[ABASE + i] !== ref_attr[i]) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  // Present one byte, wait for acceptance and for the block to go idle again.
  task automatic send(input logic [7:0] c, input logic [7:0] a, output int cyc);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 5000) begin @(negedge clk); guard++; end
    last_wb = wr_log.size();
    last_rb = rd_log.size();
    in_valid = 1'b1; in_char = c; in_attr = a;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < 5000) begin cyc++; @(negedge clk); end
  endtask

  task automatic do_byte(input logic [7:0] c, input logic [7:0] a, input string tag);
    int cyc;
    int exp_busy;
    send(c, a, cyc);
    model_byte(c, a, exp_busy);
    check({tag, "_busy"}, 32'(cyc), 32'(exp_busy));
    check({tag, "_col"}, 32'(cursor_col), 32'(mcol));
    check({tag, "_row"}, 32'(cursor_row), 32'(mrow));
  endtask

  initial begin
    logic [7:0]  c;
    logic [7:0]  saved;
    logic [19:0] ent;
    int          bad;
    int          r;

    // Preload the buffer with noise; the model starts from the same contents.
    for (int i = 0; i < 4096; i++) init_mem[i] = 8'($urandom);
    for (int i = 0; i < CELLS; i++) begin
      ref_char[i] = init_mem[BASE + i];
      ref_attr[i] = init_mem[ABASE + i];
    end
    load = 1'b1;
    in_valid = 1'b1; in_char = 8'h55; in_attr = 8'h11;  // must be discarded under reset
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;

    check("rst_addr", 32'(addr), 32'h400);
    check("rst_we", 32'(we), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_col", 32'(cursor_col), 32'd0);
    check("rst_row", 32'(cursor_row), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_discard", 32'(wr_log.size()), 32'd0);

    // Single printable byte.
    do_byte(8'h41, 8'h1E, "chA");
    check("chA_nwr", 32'(wr_log.size() - last_wb), 32'd2);
    check("chA_wr0", 32'(wr_log[last_wb]), 32'({12'h400, 8'h41}));
    check("chA_wr1", 32'(wr_log[last_wb + 1]), 32'({12'h540, 8'h1E}));

    // CR mid-row and BS at column 0: no bus traffic, ready never drops.
    do_byte(8'h0D, 8'h00, "cr");
    check("cr_nwr", 32'(wr_log.size() - last_wb), 32'd0);
    do_byte(8'h08, 8'h00, "bs0");
    check("bs0_nwr", 32'(wr_log.size() - last_wb + rd_log.size() - last_rb), 32'd0);

    // Fill row 0; the 20th byte lands at the end of the row and wraps.
    for (int i = 0; i < W; i++) do_byte(8'h61 + 8'(i), 8'h2C, "row0");
    check("row0_wrc", 32'(wr_log[last_wb]), 32'({12'h413, 8'h74}));
    check("row0_wra", 32'(wr_log[last_wb + 1]), 32'({12'h553, 8'h2C}));
    check_screen("row0_screen");

    // Walk down to the last row, then LF forces a scroll.
    while (mrow < H - 1) do_byte(8'h0A, 8'h00, "lf");
    saved = ref_char[W];
    do_byte(8'h0A, 8'h5A, "scroll");
    check("scroll_rd0", 32'(rd_log[last_rb]), 32'h414);
    check("scroll_wr0", 32'(wr_log[last_wb]), 32'({12'h400, saved}));
    check("scroll_rda", 32'(rd_log[last_rb + 300]), 32'h554);
    ent = wr_log[last_wb + 300];
    check("scroll_wra", 32'(ent[19:8]), 32'h540);
    check("scroll_nrd", 32'(rd_log.size() - last_rb), 32'd600);
    check("scroll_nwr", 32'(wr_log.size() - last_wb), 32'd640);
    check("scroll_blank", 32'(mem[12'h52C]), 32'h20);
    check("scroll_attr", 32'(mem[12'h67F]), 32'h5A);
    check_screen("scroll_screen");

    // Form feed clears both planes in address order.
    do_byte(8'h0C, 8'h07, "ff");
    check("ff_nwr", 32'(wr_log.size() - last_wb), 32'd640);
    bad = 0;
    for (int i = 0; i < 2 * CELLS; i++) begin
      if (wr_log[last_wb + i] !== {12'(BASE + i), (i < CELLS) ? 8'h20 : 8'h07}) bad++;
    end
    check("ff_seq", 32'(bad), 32'd0);
    check_screen("ff_screen");

    // Randomised byte stream against the screen model.
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6) c = 8'h0A;
      else if (r < 10) c = 8'h0D;
      else if (r < 14) c = 8'h08;
      else if (r == 14) c = 8'h0C;
      else begin
        c = 8'($urandom_range(0, 255));
        while (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = 8'($urandom_range(0, 255));
      end
      do_byte(c, 8'($urandom), "rnd");
      if (n % 20 == 19) check_screen("rnd_screen");
    end

    // Reset in the middle of a scroll.
    while (mrow < H - 1) do_byte(8'h0A, 8'h00, "lf2");
    @(negedge clk);
    in_valid = 1'b1; in_char = 8'h0A; in_attr = 8'h33;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (499) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_we", 32'(we), 32'd0);
    check("mid_oe", 32'(oe), 32'd0);
    check("mid_col", 32'(cursor_col), 32'd0);
    check("mid_row", 32'(cursor_row), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_ready", 32'(in_ready), 32'd1);
    mcol = 0; mrow = 0;
    resync_model();
    do_byte(8'h42, 8'h3C, "chB");
    check("chB_wr0", 32'(wr_log[last_wb]), 32'({12'h400, 8'h42}));
    check_screen("chB_screen");

    check("no_we_oe_overlap", 32'(n_conflict), 32'd0);
    check("no_idle_strobe", 32'(n_idle_strobe), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
